// File: rtl/sysid_boot_checker.sv
// Boot-time reader for the sysid slave: waits a settle delay, reads the ID and
// timestamp words, compares them with build-time constants and holds the verdict.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter bit          CHECK_TS       = 1'b0,
  parameter int          STARTUP_DELAY  = 16,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        recheck,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  input  logic        sysid_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] SETTLE_INIT = 16'(STARTUP_DELAY - 1);
  localparam logic [15:0] STALL_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] settle_cnt;
  logic [15:0] stall_cnt;
  logic        stall_last;
  logic        id_ok_d, ts_ok_d, timeout_d;
  logic [31:0] id_value_d, ts_value_d;

  // Avalon read: read/address are held from the first strobe cycle until the
  // cycle where waitrequest is low (the transfer), or until the stall limit expires.
  assign stall_last = sysid_waitrequest && (stall_cnt == STALL_LAST);
  assign fsm_state  = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SETTLE;
      settle_cnt <= SETTLE_INIT;
      stall_cnt  <= '0;
    end else begin
      state <= state_next;
      if (state == SETTLE && settle_cnt != '0)
        settle_cnt <= settle_cnt - 16'd1;
      if (state_next != state)
        stall_cnt <= '0;
      else if (sysid_read && sysid_waitrequest)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SETTLE: if (settle_cnt == '0) state_next = RD_ID;
      RD_ID: begin
        if (!sysid_waitrequest)  state_next = RD_TS;
        else if (stall_last)     state_next = DONE;
      end
      RD_TS:  if (!sysid_waitrequest || stall_last) state_next = DONE;
      DONE:   if (recheck) state_next = RD_ID;
      default: state_next = SETTLE;
    endcase
  end

  always_comb begin
    sysid_read    = (state == RD_ID) || (state == RD_TS);
    sysid_address = (state == RD_TS);
  end

  // A timed-out read leaves its word and ok flag untouched.
  always_comb begin
    id_ok_d    = id_ok;
    ts_ok_d    = ts_ok;
    timeout_d  = timeout_err;
    id_value_d = id_value;
    ts_value_d = ts_value;
    case (state)
      RD_ID: begin
        if (!sysid_waitrequest) begin
          id_value_d = sysid_readdata;
          id_ok_d    = (sysid_readdata == EXPECTED_ID);
        end else if (stall_last) begin
          timeout_d = 1'b1;
        end
      end
      RD_TS: begin
        if (!sysid_waitrequest) begin
          ts_value_d = sysid_readdata;
          ts_ok_d    = (sysid_readdata == EXPECTED_TS);
        end else if (stall_last) begin
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        if (recheck) begin
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      busy        <= (state_next != DONE);
      done        <= (state_next == DONE);
      pass        <= (state_next == DONE) && id_ok_d && (ts_ok_d || !CHECK_TS) && !timeout_d;
      id_ok       <= id_ok_d;
      ts_ok       <= ts_ok_d;
      timeout_err <= timeout_d;
      id_value    <= id_value_d;
      ts_value    <= ts_value_d;
    end
  end

endmodule
